// File: rtl/speicher_zugriff_pkg.sv
// ============================================================================
// speicher_zugriff_pkg : shared processor constants (access FSM states, widths)
// Revision: 1.0
// ============================================================================
`default_nettype none

package speicher_zugriff_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LESEN     = 3'd1,
    WARTEN    = 3'd2,
    SCHREIBEN = 3'd3,
    FERTIG    = 3'd4
  } zustand_t;

  typedef enum logic [1:0] {
    BREITE_BYTE    = 2'b00,
    BREITE_HALB    = 2'b01,
    BREITE_WORT    = 2'b10,
    BREITE_ILLEGAL = 2'b11
  } breite_t;

  localparam int unsigned LANE_BITS = 32;

  function automatic logic ist_ausgerichtet(breite_t breite, logic [1:0] adr_lo);
    case (breite)
      BREITE_BYTE: return 1'b1;
      BREITE_HALB: return ~adr_lo[0];
      BREITE_WORT: return (adr_lo == 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/speicher_zugriff_if.sv
// ============================================================================
// speicher_zugriff_if : request/response bus between a requester and the
//                       memory access unit
// Revision: 1.0
// ============================================================================
`default_nettype none

interface speicher_zugriff_if #(
  parameter int WORDS    = 256,
  parameter int WORDSIZE = 32
);
  localparam int AW = $clog2(WORDS) + 2;

  logic                Start;
  logic                Schreiben;
  logic [1:0]          Breite;
  logic                Vorzeichen;
  logic [AW-1:0]       Adresse;
  logic [WORDSIZE-1:0] DatenRein;
  logic                Bereit;
  logic                Fertig;
  logic                Fehler;
  logic [WORDSIZE-1:0] DatenRaus;

  modport master (
    output Start, Schreiben, Breite, Vorzeichen, Adresse, DatenRein,
    input  Bereit, Fertig, Fehler, DatenRaus
  );

  modport slave (
    input  Start, Schreiben, Breite, Vorzeichen, Adresse, DatenRein,
    output Bereit, Fertig, Fehler, DatenRaus
  );
endinterface

`default_nettype wire

// File: rtl/speicher_ausrichtung.sv
// ============================================================================
// speicher_ausrichtung : little-endian lane extraction/extension for loads
//                        and lane merge for sub-word stores
// Revision: 1.0
// ============================================================================
`default_nettype none

module speicher_ausrichtung
  import speicher_zugriff_pkg::*;
(
  input  breite_t     breite_i,
  input  logic        vorzeichen_i,
  input  logic [1:0]  versatz_i,
  input  logic [31:0] wort_i,
  input  logic [31:0] daten_i,
  output logic [31:0] lade_o,
  output logic [31:0] merge_o
);
  logic [4:0]  w_schieben;
  logic [31:0] w_verschoben;
  logic [31:0] w_maske;

  assign w_schieben   = {versatz_i, 3'b000};
  assign w_verschoben = wort_i >> w_schieben;

  always_comb begin
    lade_o  = wort_i;
    w_maske = 32'hFFFF_FFFF;
    case (breite_i)
      BREITE_BYTE: begin
        lade_o  = {{24{vorzeichen_i & w_verschoben[7]}}, w_verschoben[7:0]};
        w_maske = 32'h0000_00FF << w_schieben;
      end
      BREITE_HALB: begin
        lade_o  = {{16{vorzeichen_i & w_verschoben[15]}}, w_verschoben[15:0]};
        w_maske = 32'h0000_FFFF << w_schieben;
      end
      default: ;
    endcase
    // Store data arrives right-aligned; move it into the addressed lane(s).
    merge_o = (wort_i & ~w_maske) | ((daten_i << w_schieben) & w_maske);
  end

endmodule

`default_nettype wire

// File: rtl/speicher_zugriff.sv
// ============================================================================
// speicher_zugriff : byte/halfword/word load-store unit in front of a
//                    single-port RAM with registered read
// Revision: 1.0
// ============================================================================
`default_nettype none

module speicher_zugriff
  import speicher_zugriff_pkg::*;
#(
  parameter int WORDSIZE = 32,
  parameter int WORDS    = 256
) (
  input  logic                       Clock,
  input  logic                       Reset,
  speicher_zugriff_if.slave          bus,
  output logic                       RamSchreibenAn,
  output logic [WORDSIZE-1:0]        RamDatenRein,
  output logic [$clog2(WORDS)-1:0]   RamAdresse,
  input  logic [WORDSIZE-1:0]        RamDatenRaus
);
  localparam int AW = $clog2(WORDS) + 2;

  zustand_t            zustand_q, zustand_d;
  logic                schreiben_q, schreiben_d;
  breite_t             breite_q, breite_d;
  logic                vorzeichen_q, vorzeichen_d;
  logic [AW-1:0]       adresse_q, adresse_d;
  logic [WORDSIZE-1:0] puffer_q, puffer_d;
  logic [WORDSIZE-1:0] daten_raus_q, daten_raus_d;
  logic                fehler_q, fehler_d;

  logic [31:0]         w_lade;
  logic [31:0]         w_merge;
  logic                w_ok;

  speicher_ausrichtung u_ausrichtung (
    .breite_i     (breite_q),
    .vorzeichen_i (vorzeichen_q),
    .versatz_i    (adresse_q[1:0]),
    .wort_i       (RamDatenRaus),
    .daten_i      (puffer_q),
    .lade_o       (w_lade),
    .merge_o      (w_merge)
  );

  assign w_ok = ist_ausgerichtet(breite_t'(bus.Breite), bus.Adresse[1:0]);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand_q    <= IDLE;
      schreiben_q  <= 1'b0;
      breite_q     <= BREITE_BYTE;
      vorzeichen_q <= 1'b0;
      adresse_q    <= '0;
      puffer_q     <= '0;
      daten_raus_q <= '0;
      fehler_q     <= 1'b0;
    end else begin
      zustand_q    <= zustand_d;
      schreiben_q  <= schreiben_d;
      breite_q     <= breite_d;
      vorzeichen_q <= vorzeichen_d;
      adresse_q    <= adresse_d;
      puffer_q     <= puffer_d;
      daten_raus_q <= daten_raus_d;
      fehler_q     <= fehler_d;
    end
  end

  always_comb begin
    zustand_d    = zustand_q;
    schreiben_d  = schreiben_q;
    breite_d     = breite_q;
    vorzeichen_d = vorzeichen_q;
    adresse_d    = adresse_q;
    puffer_d     = puffer_q;
    daten_raus_d = daten_raus_q;
    fehler_d     = fehler_q;
    case (zustand_q)
      IDLE: begin
        if (bus.Start) begin
          schreiben_d  = bus.Schreiben;
          breite_d     = breite_t'(bus.Breite);
          vorzeichen_d = bus.Vorzeichen;
          adresse_d    = bus.Adresse;
          puffer_d     = bus.DatenRein;
          fehler_d     = ~w_ok;
          if (!w_ok)
            zustand_d = FERTIG;
          else if (bus.Schreiben && (breite_t'(bus.Breite) == BREITE_WORT))
            zustand_d = SCHREIBEN;
          else
            zustand_d = LESEN;
        end
      end
      LESEN: zustand_d = WARTEN;
      WARTEN: begin
        // Sub-word stores keep the merged word in the data buffer for the write.
        if (schreiben_q) begin
          puffer_d  = w_merge;
          zustand_d = SCHREIBEN;
        end else begin
          daten_raus_d = w_lade;
          zustand_d    = FERTIG;
        end
      end
      SCHREIBEN: zustand_d = FERTIG;
      FERTIG:    zustand_d = IDLE;
      default:   zustand_d = IDLE;
    endcase
  end

  assign RamSchreibenAn = (zustand_q == SCHREIBEN);
  assign RamDatenRein   = puffer_q;
  assign RamAdresse     = (zustand_q == IDLE) ? '0 : adresse_q[AW-1:2];

  assign bus.Bereit     = (zustand_q == IDLE);
  assign bus.Fertig     = (zustand_q == FERTIG);
  assign bus.Fehler     = (zustand_q == FERTIG) && fehler_q;
  assign bus.DatenRaus  = daten_raus_q;

endmodule

`default_nettype wire

// File: tb/tb_speicher_zugriff.sv
// ============================================================================
// tb_speicher_zugriff : scoreboard bench for speicher_zugriff with a RAM model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_speicher_zugriff;
  localparam int WORDS = 256;
  localparam int WS    = 32;
  localparam int AW    = 10;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              RamSchreibenAn;
  logic [WS-1:0]     RamDatenRein;
  logic [WS-1:0]     RamDatenRaus;
  logic [7:0]        RamAdresse;
  logic              lade_init;

  always #5 Clock = ~Clock;

  speicher_zugriff_if #(.WORDS(WORDS), .WORDSIZE(WS)) bus ();

  speicher_zugriff #(.WORDSIZE(WS), .WORDS(WORDS)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .bus            (bus),
    .RamSchreibenAn (RamSchreibenAn),
    .RamDatenRein   (RamDatenRein),
    .RamAdresse     (RamAdresse),
    .RamDatenRaus   (RamDatenRaus)
  );

  function automatic logic [31:0] init_wert(int i);
    if (i == 0) return 32'h8020_FFFF;
    if (i == 1) return 32'hE820_0000;
    return (i * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  // Team RAM: registered read, no reset, read only while not writing
  logic [31:0] mem [WORDS];
  always @(posedge Clock) begin
    if (lade_init) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= init_wert(i);
    end else if (RamSchreibenAn) begin
      mem[RamAdresse] <= RamDatenRein;
    end else begin
      RamDatenRaus <= mem[RamAdresse];
    end
  end

  typedef struct {
    logic [31:0] daten;
    logic        fehler;
    int          zyklus;
    int          schreibzugriffe;
  } erw_t;

  erw_t        sb[$];
  logic [31:0] ref_mem [WORDS];
  logic [31:0] letzte_daten;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          timeouts = 0;
  logic        alles_fertig = 1'b0;

  // ---------------- monitor: sole owner of checks/errors ----------------
  initial begin : monitor
    int   wr_cnt;
    logic r;
    erw_t e;
    wr_cnt = 0;
    forever begin
      @(posedge Clock);
      r = Reset;
      cyc++;
      #1;
      if (alles_fertig) begin
        for (int i = 0; i < WORDS; i++) begin
          checks++;
          if (mem[i] !== ref_mem[i]) begin
            errors++;
            $display("FAIL ram_inhalt[%0d]: actual %h required %h", i, mem[i], ref_mem[i]);
          end
        end
        checks++;
        if (timeouts != 0) begin
          errors++;
          $display("FAIL timeout: actual %0d expired waits required 0", timeouts);
        end
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL ausstehend: actual %0d pending completions required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (r) begin
        checks++;
        if (!(bus.Bereit === 1'b1 && bus.Fertig === 1'b0 && bus.Fehler === 1'b0 &&
              bus.DatenRaus === 32'h0)) begin
          errors++;
          $display("FAIL reset_zustand: actual Bereit=%b Fertig=%b Fehler=%b DatenRaus=%h required 1 0 0 00000000",
                   bus.Bereit, bus.Fertig, bus.Fehler, bus.DatenRaus);
        end
        wr_cnt = 0;
      end else begin
        if (RamSchreibenAn === 1'b1) wr_cnt++;
        checks++;
        if (bus.Fehler === 1'b1 && bus.Fertig !== 1'b1) begin
          errors++;
          $display("FAIL fehler_ohne_fertig: actual Fehler=1 Fertig=%b required Fehler=0", bus.Fertig);
        end
        if (bus.Fertig === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unerwartetes_fertig: actual Fertig=1 at cycle %0d required no completion", cyc);
          end else begin
            e = sb.pop_front();
            if (bus.DatenRaus !== e.daten) begin
              errors++;
              $display("FAIL daten_raus: actual %h required %h", bus.DatenRaus, e.daten);
            end
            checks++;
            if (bus.Fehler !== e.fehler) begin
              errors++;
              $display("FAIL fehler: actual %b required %b", bus.Fehler, e.fehler);
            end
            checks++;
            if (cyc != e.zyklus) begin
              errors++;
              $display("FAIL latenz: actual Fertig at cycle %0d required %0d", cyc, e.zyklus);
            end
            checks++;
            if (wr_cnt != e.schreibzugriffe) begin
              errors++;
              $display("FAIL ram_schreiben: actual %0d write cycles required %0d", wr_cnt, e.schreibzugriffe);
            end
          end
          wr_cnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus + reference model ----------------
  task automatic warte_bereit();
    int n = 0;
    while (bus.Bereit !== 1'b1 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (bus.Bereit !== 1'b1) timeouts++;
  endtask

  task automatic anfrage(input logic s, input logic [1:0] b, input logic vz,
                         input logic [AW-1:0] a, input logic [31:0] d, input int halten);
    erw_t        e;
    logic [1:0]  off;
    logic [31:0] w, v, maske;
    logic        err;
    warte_bereit();
    off = a[1:0];
    w   = ref_mem[a[AW-1:2]];
    err = (b == 2'b11) || (b == 2'b01 && a[0]) || (b == 2'b10 && off != 2'b00);
    e.fehler = err;
    e.schreibzugriffe = 0;
    if (err) begin
      e.zyklus = cyc + 1;
    end else if (!s) begin
      v = w >> (8 * off);
      if (b == 2'b00) begin
        v = v & 32'h0000_00FF;
        if (vz && v[7]) v = v | 32'hFFFF_FF00;
      end else if (b == 2'b01) begin
        v = v & 32'h0000_FFFF;
        if (vz && v[15]) v = v | 32'hFFFF_0000;
      end
      letzte_daten = v;
      e.zyklus = cyc + 3;
    end else begin
      e.schreibzugriffe = 1;
      if (b == 2'b10) begin
        ref_mem[a[AW-1:2]] = d;
        e.zyklus = cyc + 2;
      end else begin
        maske = ((b == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * off);
        ref_mem[a[AW-1:2]] = (w & ~maske) | ((d << (8 * off)) & maske);
        e.zyklus = cyc + 4;
      end
    end
    e.daten = letzte_daten;
    sb.push_back(e);
    bus.Start = 1'b1; bus.Schreiben = s; bus.Breite = b; bus.Vorzeichen = vz;
    bus.Adresse = a; bus.DatenRein = d;
    @(negedge Clock);
    // Extra Start cycles while busy carry a word store to word 0 that must be ignored
    for (int i = 1; i < halten; i++) begin
      bus.Schreiben = 1'b1; bus.Breite = 2'b10; bus.Adresse = '0; bus.DatenRein = 32'hDEAD_BEEF;
      @(negedge Clock);
    end
    bus.Start = 1'b0;
  endtask

  task automatic reset_in_warten();
    warte_bereit();
    bus.Start = 1'b1; bus.Schreiben = 1'b1; bus.Breite = 2'b00; bus.Vorzeichen = 1'b0;
    bus.Adresse = 10'd6; bus.DatenRein = 32'h0000_0011;
    @(negedge Clock);
    bus.Start = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    letzte_daten = 32'h0;
  endtask

  initial begin : stimulus
    int n;
    logic [AW-1:0] a;
    Reset = 1'b1; lade_init = 1'b1;
    bus.Start = 1'b0; bus.Schreiben = 1'b0; bus.Breite = 2'b00; bus.Vorzeichen = 1'b0;
    bus.Adresse = '0; bus.DatenRein = '0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_wert(i);
    letzte_daten = 32'h0;
    @(negedge Clock);
    lade_init = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    anfrage(1'b0, 2'b10, 1'b0, 10'd0, 32'h0, 1);           // word load -> 8020FFFF
    anfrage(1'b0, 2'b00, 1'b1, 10'd1, 32'h0, 1);           // -> FFFFFFFF
    anfrage(1'b0, 2'b00, 1'b0, 10'd1, 32'h0, 1);           // -> 000000FF
    anfrage(1'b0, 2'b01, 1'b1, 10'd2, 32'h0, 1);           // -> FFFF8020
    anfrage(1'b1, 2'b00, 1'b0, 10'd6, 32'h0000_00AB, 1);   // word 1 -> E8AB0000
    anfrage(1'b0, 2'b10, 1'b0, 10'd4, 32'h0, 1);
    anfrage(1'b0, 2'b10, 1'b0, 10'd2, 32'h0, 1);           // misaligned word
    anfrage(1'b0, 2'b11, 1'b0, 10'd0, 32'h0, 1);           // illegal width
    anfrage(1'b1, 2'b01, 1'b0, 10'd9, 32'h0000_1234, 1);   // misaligned halfword store
    anfrage(1'b1, 2'b10, 1'b0, 10'd8, 32'hCAFE_F00D, 1);
    anfrage(1'b1, 2'b01, 1'b0, 10'd10, 32'hFFFF_5A5A, 1);
    anfrage(1'b0, 2'b10, 1'b0, 10'd8, 32'h0, 1);
    reset_in_warten();
    anfrage(1'b0, 2'b10, 1'b0, 10'd4, 32'h0, 3);           // Start held while busy
    anfrage(1'b0, 2'b00, 1'b1, 10'd7, 32'h0, 1);
    anfrage(1'b0, 2'b10, 1'b0, 10'd0, 32'h0, 1);

    for (int k = 0; k < 80; k++) begin
      a = AW'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      anfrage(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              a, $urandom, 1);
    end

    n = 0;
    while ((sb.size() != 0 || bus.Bereit !== 1'b1) && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 50) timeouts++;
    @(negedge Clock);
    alles_fertig = 1'b1;
    repeat (5) @(negedge Clock);
    $display("FAIL monitor_stillstand: actual no summary required summary");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/speicher_zugriff.md
SPEICHER_ZUGRIFF -- requirements
Module: speicher_zugriff

Interface
REQ-001 SHALL have parameter WORDSIZE, default 32, RAM word width in bits (fixed at 32 for lane logic).
REQ-002 SHALL have parameter WORDS, default 256, RAM depth in words.
REQ-003 SHALL have port Clock  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  in  1  request strobe, accepted only while Bereit=1.
REQ-006 SHALL have port Schreiben  in  1  1=store, 0=load.
REQ-007 SHALL have port Breite  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port Vorzeichen  in  1  1=sign-extend sub-word loads, 0=zero-extend.
REQ-009 SHALL have port Adresse  in  $clog2(WORDS)+2  byte address.
REQ-010 SHALL have port DatenRein  in  WORDSIZE  store data, right-aligned.
REQ-011 SHALL have port Bereit  out  1  idle, ready for Start.
REQ-012 SHALL have port Fertig  out  1  one-cycle completion pulse.
REQ-013 SHALL have port Fehler  out  1  valid with Fertig; misaligned or illegal Breite.
REQ-014 SHALL have port DatenRaus  out  WORDSIZE  load result, valid with Fertig, held until next completion.
REQ-015 SHALL have ports RamSchreibenAn out 1, RamDatenRein out WORDSIZE, RamAdresse out $clog2(WORDS), RamDatenRaus in WORDSIZE: master side of the team RAM (registered read, 1-cycle latency; read only when RamSchreibenAn=0).

Function
REQ-016 SHALL implement states IDLE, LESEN, WARTEN, SCHREIBEN, FERTIG.
REQ-017 SHALL latch Schreiben, Breite, Vorzeichen, Adresse, DatenRein at the edge where Start=1 in IDLE; Start outside IDLE is ignored.
REQ-018 SHALL drive RamAdresse = latched Adresse[top:2] in every state except IDLE (IDLE: 0).
REQ-019 SHALL drive RamSchreibenAn=1 only in SCHREIBEN, decoded from state.
REQ-020 SHALL check alignment on accept: halfword needs Adresse[0]=0, word needs Adresse[1:0]=0, Breite=11 illegal; failure -> FERTIG with Fehler=1, no RAM write, DatenRaus unchanged.
REQ-021 Load: IDLE -> LESEN -> WARTEN -> FERTIG; at WARTEN->FERTIG edge capture RamDatenRaus, select lane (little-endian, byte n = bits 8n+7:8n), extend per Vorzeichen; Fertig in 4th cycle counting Start cycle as 1.
REQ-022 Word store: IDLE -> SCHREIBEN -> FERTIG; RamDatenRein = latched DatenRein; Fertig in 3rd cycle.
REQ-023 Byte/halfword store: IDLE -> LESEN -> WARTEN -> SCHREIBEN -> FERTIG (read-modify-write); merge replaces only addressed lane(s) of captured word; Fertig in 5th cycle.
REQ-024 FERTIG SHALL last exactly one cycle, then IDLE; Bereit=1 only in IDLE, so back-to-back Start is accepted the cycle after Fertig.
REQ-025 Fehler SHALL be 0 whenever Fertig=0.

Reset
REQ-026 On Reset=1 at an edge: state IDLE, Bereit=1, Fertig=0, Fehler=0, DatenRaus=0, latched request cleared; Reset wins over simultaneous Start.
REQ-027 Reset mid-operation SHALL abort without completion pulse; a RAM write driven in SCHREIBEN on the reset edge commits (RAM has no reset).

Structure
REQ-028 State encoding and Breite codes SHALL live in a shared package with the processor's other constants.
REQ-029 Lane extraction/extension and store merge SHALL be one combinational sub-module, speicher_ausrichtung.

Verification
REQ-030 RAM word 0 = 32'h8020FFFF; word load addr 0 -> Fertig cycle 4, DatenRaus=32'h8020FFFF, Fehler=0.
REQ-031 Byte load addr 1, Vorzeichen=1 -> 32'hFFFFFFFF; Vorzeichen=0 -> 32'h000000FF; halfword load addr 2, Vorzeichen=1 -> 32'hFFFF8020.
REQ-032 Byte store 8'hAB to addr 6 over word 1 = 32'hE8200000 -> word 1 = 32'hE8AB0000, Fertig cycle 5, exactly one RamSchreibenAn cycle.
REQ-033 Word load addr 2 and Breite=11 -> Fertig cycle 2, Fehler=1, no RamSchreibenAn, DatenRaus unchanged.
REQ-034 Reset asserted in WARTEN of a byte store -> no write, no Fertig, Bereit=1 next cycle; Start during busy ignored, back-to-back loads complete in order.
